seq_detect_arbiter: RTL
=======================

// Module: seq_detect_arbiter
// PURPOSE
//   Shares one serial Moore sequence detector (overlapping 0100/1001, registered z) among N_REQ requesters.
//   Round-robin grants the detector to one requester per frame and clears the detector before each frame.
//   Streams the winner's bits into det_x and counts det_z pulses; reports the match count on done.
// PARAMETERS
//   N_REQ  4  number of requesters
//   ID_W   2  width of done_id, equals clog2(N_REQ)
//   LEN_W  8  frame length width, in bits per frame
//   CNT_W  8  match counter width
// PORTS
//   clk        in   1      single clock, posedge
//   reset      in   1      synchronous, active-high
//   req        in   N_REQ  level request per requester
//   req_bit    in   N_REQ  current serial bit per requester
//   frame_len  in   LEN_W  bits per frame; sampled at grant
//   gnt        out  N_REQ  one-hot grant, registered
//   bit_rd     out  N_REQ  one-hot; req_bit[i] consumed this cycle, requester advances next cycle
//   det_x      out  1      detector input; req_bit[winner] in RUN, else 0
//   det_reset  out  1      detector synchronous clear; = reset | (state==CLEAR)
//   det_z      in   1      detector Moore output
//   done       out  1      one-cycle pulse, frame complete
//   done_id    out  ID_W   index of finished requester; valid with done
//   match_cnt  out  CNT_W  detections in the frame; valid with done
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Reset values: gnt=0, bit_rd=0, det_x=0, done=0, done_id=0, match_cnt=0, busy=0.
//   Reset also sets state=IDLE and the RR pointer to N_REQ-1, so req[0] has top priority first.
//   Reset mid-frame aborts the frame with no done; det_reset stays high while reset is high.
//   States:
//   - IDLE: if req!=0, pick the first set req after the pointer (circular); latch idx, pointer=idx,
//     len=frame_len; go to CLEAR. Else stay.
//   - CLEAR (1 cycle): gnt[idx]=1, det_reset=1, cnt=0. Go to RUN, or to DONE if len==0.
//   - RUN (len cycles): gnt[idx]=1, bit_rd[idx]=1, det_x=req_bit[idx]; remaining bits decrement.
//     On the last bit, go to DRAIN.
//   - DRAIN (1 cycle): gnt held, bit_rd=0, det_x=0. Captures z of the last bit; go to DONE.
//   - DONE (1 cycle): gnt held, done=1, done_id=idx, match_cnt=cnt; go to IDLE.
//   Counting: in every RUN and DRAIN cycle, det_z==1 increments cnt.
//   - det_z lags det_x by one cycle (Moore detector), hence the DRAIN cycle.
//   - The first RUN cycle sees det_z=0 after CLEAR.
//   - cnt saturates at 2^CNT_W-1, no wrap.
//   match_cnt and done_id hold their values until the next DONE.
//   Timing: req seen in IDLE at cycle t -> CLEAR t+1 -> RUN t+2..t+L+1 -> DRAIN t+L+2 -> DONE t+L+3.
//   With len==0, done occurs at t+2 with match_cnt=0.
//   The grant is non-preemptive; req dropping during a frame is ignored and the frame still runs len bits.
//   req still high at DONE is a new request; it is re-arbitrated in IDLE after the others (round-robin).
//   frame_len changes after the grant do not affect the current frame.
//   At least one IDLE cycle separates frames.
// TESTING
//   1. Single frame: req=0001, frame_len=4, bits 0,1,0,0.
//      -> gnt=0001 at t+1, bit_rd for 4 cycles, done at t+7, done_id=0, match_cnt=1.
//   2. Overlap: req[2], frame_len=7, bits 1,0,0,1,0,0,1.
//      -> match_cnt=3 (1001 at bits 1-4, 0100 at bits 3-6, 1001 at bits 4-7), done_id=2.
//   3. Round-robin: req=1010 held through two frames, frame_len=2.
//      -> first grant to 1, then 3, then 1; no requester starved.
//   4. Zero length: frame_len=0, req=0100.
//      -> CLEAR only, done at t+2, match_cnt=0, bit_rd never asserted.
//   5. Reset mid-RUN (after 3 of 8 bits).
//      -> next cycle: all outputs at reset values, det_reset=1, no done; next frame counts from 0.
//   6. Saturation: CNT_W=2, bits 1001001001001.
//      -> match_cnt=3, not wrapped.

Source files
------------

// File: rtl/seq_detect_arbiter.sv
// seq_detect_arbiter: round-robin front end that lends one external serial
// Moore sequence detector (0100 / 1001, overlapping, registered z) to one
// requester per frame, clears it before each frame, streams the winner's bits
// into it and reports how many detections the frame produced.
//
// Requester handshake: bit_rd[i] is high in a cycle where req_bit[i] is taken
// into det_x; the requester must present its next bit from the following
// cycle on. There is no back-pressure: once granted, a frame always consumes
// exactly the frame_len sampled at grant, whatever req does afterwards.
module seq_detect_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_bit,
    input  logic [LEN_W-1:0] frame_len,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] bit_rd,
    output logic             det_x,
    output logic             det_reset,
    input  logic             det_z,
    output logic             done,
    output logic [ID_W-1:0]  done_id,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [ID_W-1:0]  idx;        // requester owning the current frame
    logic [ID_W-1:0]  ptr;        // last granted requester (round-robin origin)
    logic [ID_W-1:0]  pick;
    logic             pick_vld;
    logic [LEN_W-1:0] rem;        // bits still to stream in this frame
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] match_q;
    logic [ID_W-1:0]  done_id_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a frame is CLEAR, len RUN cycles, DRAIN, DONE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pick_vld) state_next = S_CLEAR;
            S_CLEAR: state_next = (rem == '0) ? S_DONE : S_RUN;
            S_RUN:   if (rem == LEN_W'(1)) state_next = S_DRAIN;
            S_DRAIN: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Round-robin pick: first set req strictly after ptr, wrapping to index 0.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_vld && req[i] && (i > int'(ptr))) begin
                pick_vld = 1'b1;
                pick     = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_vld && req[i]) begin
                pick_vld = 1'b1;
                pick     = ID_W'(i);
            end
        end
    end

    // Saturating increment of the match counter on a detector hit.
    always_comb begin
        cnt_inc = cnt;
        if (det_z && (cnt != {CNT_W{1'b1}})) cnt_inc = cnt + CNT_W'(1);
    end

    // Frame datapath: grant latch, bit countdown, match counting, result hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= ID_W'(N_REQ - 1);
            idx       <= '0;
            rem       <= '0;
            cnt       <= '0;
            match_q   <= '0;
            done_id_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        idx <= pick;
                        ptr <= pick;
                        rem <= frame_len;
                    end
                end
                S_CLEAR: begin
                    cnt <= '0;
                    if (rem == '0) begin
                        match_q   <= '0;
                        done_id_q <= idx;
                    end
                end
                S_RUN: begin
                    rem <= rem - LEN_W'(1);
                    cnt <= cnt_inc;
                end
                S_DRAIN: begin
                    // z of the last streamed bit arrives here, one cycle late.
                    cnt       <= cnt_inc;
                    match_q   <= cnt_inc;
                    done_id_q <= idx;
                end
                default: ;
            endcase
        end
    end

    // Output decode from the registered state and grant index.
    always_comb begin
        gnt    = '0;
        bit_rd = '0;
        det_x  = 1'b0;
        done   = 1'b0;
        if (state != S_IDLE) gnt = N_REQ'(1) << idx;
        if (state == S_RUN) begin
            bit_rd = N_REQ'(1) << idx;
            det_x  = req_bit[idx];
        end
        if (state == S_DONE) done = 1'b1;
    end

    assign det_reset = reset | (state == S_CLEAR);
    assign busy      = (state != S_IDLE);
    assign done_id   = done_id_q;
    assign match_cnt = match_q;

endmodule
